// File: rtl/char2bin.sv
// char2bin: ASCII hex text lines -> framed byte stream with last/err markers.
// Each text line becomes one frame; a one-byte hold stage lets bin_last ride
// on the final data byte. Input cannot be stalled; output uses valid/ready.
// Optional macro CHAR2BIN_STATS_EN adds saturating frm_cnt/err_cnt outputs.
module char2bin #(
  parameter int MAX_LEN = 1514
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       char_vld,
  input  logic [7:0] char_data,
  output logic       bin_vld,
  input  logic       bin_rdy,
  output logic [7:0] bin_data,
  output logic       bin_last,
  output logic       bin_err,
  output logic       err_vld,
  output logic [1:0] err_code
`ifdef CHAR2BIN_STATS_EN
  ,
  output logic [7:0] frm_cnt,
  output logic [7:0] err_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_LEN + 2);

  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_ODD     = 2'd2;
  localparam logic [1:0] ERR_LONG    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HI      = 2'd1,
    S_LO      = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         hi_q, hi_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               hold_vld_q, hold_vld_d;
  logic [7:0]         hold_data_q, hold_data_d;
  logic               hold_final_q, hold_final_d;
  logic               hold_err_q, hold_err_d;

  logic               out_vld_q, out_vld_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               out_err_q, out_err_d;

  logic               err_vld_q, err_vld_d;
  logic [1:0]         err_code_q, err_code_d;

  logic               is_hex, is_sep, is_term, is_ill;
  logic [3:0]         nib;
  logic               out_free;
  logic               raise;
  logic [1:0]         raise_code;
  logic               set_final;
  logic               push;
  logic               fin;
  logic [7:0]         new_byte;

  assign out_free = ~out_vld_q | bin_rdy;
  assign new_byte = {hi_q, nib};

  // Classify the incoming character and decode its nibble value.
  always_comb begin
    is_hex  = 1'b0;
    is_sep  = 1'b0;
    is_term = 1'b0;
    nib     = 4'h0;
    if (char_data >= 8'h30 && char_data <= 8'h39) begin
      is_hex = 1'b1;
      nib    = char_data[3:0];
    end else if (char_data >= 8'h41 && char_data <= 8'h46) begin
      is_hex = 1'b1;
      nib    = char_data[3:0] + 4'd9;
    end else if (char_data >= 8'h61 && char_data <= 8'h66) begin
      is_hex = 1'b1;
      nib    = char_data[3:0] + 4'd9;
    end else if (char_data == 8'h20 || char_data == 8'h09 || char_data == 8'h3A) begin
      is_sep = 1'b1;
    end else if (char_data == 8'h0A || char_data == 8'h0D) begin
      is_term = 1'b1;
    end
    is_ill = ~(is_hex | is_sep | is_term);
  end

  // Next-state: parser FSM, frame counter, hold stage and output register.
  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    cnt_d        = cnt_q;
    hold_vld_d   = hold_vld_q;
    hold_data_d  = hold_data_q;
    hold_final_d = hold_final_q;
    hold_err_d   = hold_err_q;
    out_vld_d    = out_vld_q & ~bin_rdy;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_err_d    = out_err_q;
    err_vld_d    = 1'b0;
    err_code_d   = err_code_q;
    raise        = 1'b0;
    raise_code   = 2'd0;
    set_final    = 1'b0;
    push         = 1'b0;
    fin          = 1'b0;

    if (char_vld) begin
      case (state_q)
        S_IDLE: begin
          if (is_hex) begin
            hi_d    = nib;
            state_d = S_LO;
          end else if (is_ill) begin
            raise      = 1'b1;
            raise_code = ERR_ILLEGAL;
            state_d    = S_DISCARD;
          end
        end
        S_HI: begin
          if (is_hex) begin
            hi_d    = nib;
            state_d = S_LO;
          end else if (is_term) begin
            set_final = 1'b1;
            state_d   = S_IDLE;
          end else if (is_ill) begin
            raise      = 1'b1;
            raise_code = ERR_ILLEGAL;
            state_d    = S_DISCARD;
          end
        end
        S_LO: begin
          if (is_hex) begin
            // A completed byte is dropped when the frame is already full or
            // when both the hold and the output are occupied.
            if (cnt_q == CNT_W'(MAX_LEN) || (hold_vld_q && !out_free)) begin
              raise      = 1'b1;
              raise_code = ERR_LONG;
              state_d    = S_DISCARD;
            end else begin
              push    = 1'b1;
              cnt_d   = cnt_q + CNT_W'(1);
              state_d = S_HI;
            end
          end else if (is_term) begin
            raise      = 1'b1;
            raise_code = ERR_ODD;
            state_d    = S_IDLE;
          end else if (is_sep) begin
            raise      = 1'b1;
            raise_code = ERR_ODD;
            state_d    = S_DISCARD;
          end else begin
            raise      = 1'b1;
            raise_code = ERR_ILLEGAL;
            state_d    = S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (is_term) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d == S_IDLE) cnt_d = '0;

    if (raise) begin
      err_vld_d  = 1'b1;
      err_code_d = raise_code;
    end

    // Any terminator or error closes the byte sitting in the hold.
    fin = hold_final_q | set_final | raise;

    if (hold_vld_q) begin
      if (push) begin
        out_vld_d    = 1'b1;
        out_data_d   = hold_data_q;
        out_last_d   = hold_final_q;
        out_err_d    = hold_err_q;
        hold_data_d  = new_byte;
        hold_final_d = 1'b0;
        hold_err_d   = 1'b0;
      end else if (fin && out_free) begin
        out_vld_d    = 1'b1;
        out_data_d   = hold_data_q;
        out_last_d   = 1'b1;
        out_err_d    = hold_err_q | raise;
        hold_vld_d   = 1'b0;
        hold_final_d = 1'b0;
        hold_err_d   = 1'b0;
      end else begin
        hold_final_d = fin;
        hold_err_d   = hold_err_q | raise;
      end
    end else if (push) begin
      hold_vld_d   = 1'b1;
      hold_data_d  = new_byte;
      hold_final_d = 1'b0;
      hold_err_d   = 1'b0;
    end
  end

  // State, hold and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      hi_q         <= 4'h0;
      cnt_q        <= '0;
      hold_vld_q   <= 1'b0;
      hold_data_q  <= 8'h00;
      hold_final_q <= 1'b0;
      hold_err_q   <= 1'b0;
      out_vld_q    <= 1'b0;
      out_data_q   <= 8'h00;
      out_last_q   <= 1'b0;
      out_err_q    <= 1'b0;
      err_vld_q    <= 1'b0;
      err_code_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      cnt_q        <= cnt_d;
      hold_vld_q   <= hold_vld_d;
      hold_data_q  <= hold_data_d;
      hold_final_q <= hold_final_d;
      hold_err_q   <= hold_err_d;
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_err_q    <= out_err_d;
      err_vld_q    <= err_vld_d;
      err_code_q   <= err_code_d;
    end
  end

  assign bin_vld  = out_vld_q;
  assign bin_data = out_data_q;
  assign bin_last = out_last_q;
  assign bin_err  = out_err_q;
  assign err_vld  = err_vld_q;
  assign err_code = err_code_q;

`ifdef CHAR2BIN_STATS_EN
  logic [7:0] frm_cnt_q;
  logic [7:0] err_cnt_q;

  // Saturating counters of accepted last-beats and error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frm_cnt_q <= 8'h00;
      err_cnt_q <= 8'h00;
    end else begin
      if (out_vld_q && bin_rdy && out_last_q && frm_cnt_q != 8'hFF)
        frm_cnt_q <= frm_cnt_q + 8'd1;
      if (err_vld_q && err_cnt_q != 8'hFF)
        err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign frm_cnt = frm_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_char2bin.sv
// Bench for char2bin: directed test-plan lines plus randomized text lines
// checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_char2bin;

  localparam int MAX_LEN = 4;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       reset;
  logic       char_vld;
  logic [7:0] char_data;
  logic       bin_vld;
  logic       bin_rdy;
  logic [7:0] bin_data;
  logic       bin_last;
  logic       bin_err;
  logic       err_vld;
  logic [1:0] err_code;
`ifdef CHAR2BIN_STATS_EN
  logic [7:0] frm_cnt;
  logic [7:0] err_cnt;
`endif

  int nerr = 0;
  int nchk = 0;

  logic [9:0] got_beats[$];
  logic [9:0] exp_beats[$];
  logic [1:0] got_codes[$];
  logic [1:0] exp_codes[$];

  char2bin #(.MAX_LEN(MAX_LEN)) dut (
    .clk      (clk),
    .reset    (reset),
    .char_vld (char_vld),
    .char_data(char_data),
    .bin_vld  (bin_vld),
    .bin_rdy  (bin_rdy),
    .bin_data (bin_data),
    .bin_last (bin_last),
    .bin_err  (bin_err),
    .err_vld  (err_vld),
    .err_code (err_code)
`ifdef CHAR2BIN_STATS_EN
    ,
    .frm_cnt  (frm_cnt),
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Record accepted beats and error pulses mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (bin_vld && bin_rdy) got_beats.push_back({bin_data, bin_last, bin_err});
      if (err_vld) got_codes.push_back(err_code);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_beat(input logic [7:0] d, input logic last, input logic err);
    exp_beats.push_back({d, last, err});
  endtask

  task automatic clear_q();
    got_beats.delete();
    exp_beats.delete();
    got_codes.delete();
    exp_codes.delete();
  endtask

  task automatic drain_and_compare(input string tag);
    logic [31:0] obs;
    repeat (8) @(posedge clk);
    #1;
    chk({tag, " beat count"}, got_beats.size(), exp_beats.size());
    for (int i = 0; i < exp_beats.size(); i++) begin
      obs = (i < got_beats.size()) ? {22'd0, got_beats[i]} : 32'hDEAD_BEEF;
      chk($sformatf("%s beat%0d {data,last,err}", tag, i), obs, {22'd0, exp_beats[i]});
    end
    chk({tag, " err pulse count"}, got_codes.size(), exp_codes.size());
    for (int i = 0; i < exp_codes.size(); i++) begin
      obs = (i < got_codes.size()) ? {30'd0, got_codes[i]} : 32'hDEAD_BEEF;
      chk($sformatf("%s err_code%0d", tag, i), obs, {30'd0, exp_codes[i]});
    end
    clear_q();
  endtask

  task automatic send_char(input logic [7:0] c, input int gap);
    char_vld  = 1'b1;
    char_data = c;
    @(posedge clk);
    #1;
    char_vld = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_char(s[i], gap);
  endtask

  task automatic send_q(input bq_t t);
    foreach (t[i]) send_char(t[i], int'($urandom_range(0, 2)));
  endtask

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - int'("0");
    if (c >= "A" && c <= "F") return int'(c) - int'("A") + 10;
    if (c >= "a" && c <= "f") return int'(c) - int'("a") + 10;
    return -1;
  endfunction

  // Frame-level reference: collect the bytes of each line, note the first
  // error, and emit the surviving bytes with last/err on the final one.
  task automatic model_text(input bq_t t);
    logic [7:0] frame[$];
    bit odd = 0;
    bit dead = 0;
    bit bad = 0;
    logic [3:0] hi = 4'h0;
    int v;
    foreach (t[i]) begin
      logic [7:0] c;
      c = t[i];
      v = hexval(c);
      if (c == 8'h0A || c == 8'h0D) begin
        if (!dead && odd) begin
          bad = 1;
          exp_codes.push_back(2'd2);
        end
        for (int k = 0; k < frame.size(); k++)
          exp_beat(frame[k], k == frame.size() - 1, (k == frame.size() - 1) && bad);
        frame.delete();
        odd = 0; dead = 0; bad = 0;
      end else if (dead) begin
        // characters after an error are discarded until the line ends
      end else if (v >= 0) begin
        if (!odd) begin
          hi  = v[3:0];
          odd = 1;
        end else begin
          odd = 0;
          if (frame.size() == MAX_LEN) begin
            bad = 1; dead = 1;
            exp_codes.push_back(2'd3);
          end else begin
            frame.push_back({hi, v[3:0]});
          end
        end
      end else if (c == 8'h20 || c == 8'h09 || c == ":") begin
        if (odd) begin
          bad = 1; dead = 1;
          exp_codes.push_back(2'd2);
        end
      end else begin
        bad = 1; dead = 1;
        exp_codes.push_back(2'd1);
      end
    end
  endtask

  function automatic logic [7:0] rand_char();
    string hexs;
    int r;
    hexs = "0123456789abcdefABCDEF";
    r = int'($urandom_range(0, 21));
    case (r)
      12, 13:  return 8'h20;
      14:      return ":";
      15:      return 8'h09;
      16:      return ($urandom_range(0, 1) == 0) ? "G" : "z";
      17:      return 8'h0D;
      default: return hexs[int'($urandom_range(0, 21))];
    endcase
  endfunction

  initial begin
    bq_t t;
    reset     = 1'b1;
    char_vld  = 1'b0;
    char_data = 8'h00;
    bin_rdy   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset bin_vld",  bin_vld,  0);
    chk("reset bin_data", bin_data, 0);
    chk("reset bin_last", bin_last, 0);
    chk("reset bin_err",  bin_err,  0);
    chk("reset err_vld",  err_vld,  0);
    chk("reset err_code", err_code, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_q();

    send_str("0A1b\n", 1);
    exp_beat(8'h0A, 0, 0);
    exp_beat(8'h1B, 1, 0);
    drain_and_compare("0A1b");

    send_str("DE:AD BE\r\n", 0);
    exp_beat(8'hDE, 0, 0);
    exp_beat(8'hAD, 0, 0);
    exp_beat(8'hBE, 1, 0);
    drain_and_compare("DEADBE crlf");

    send_str("12G4\n55\n", 2);
    exp_beat(8'h12, 1, 1);
    exp_beat(8'h55, 1, 0);
    exp_codes.push_back(2'd1);
    drain_and_compare("illegal G");
    chk("err_code held", err_code, 1);

    send_str("123\n\n", 1);
    exp_beat(8'h12, 1, 1);
    exp_codes.push_back(2'd2);
    drain_and_compare("odd nibbles");

    send_str("0102030405\n", 0);
    exp_beat(8'h01, 0, 0);
    exp_beat(8'h02, 0, 0);
    exp_beat(8'h03, 0, 0);
    exp_beat(8'h04, 1, 1);
    exp_codes.push_back(2'd3);
    drain_and_compare("length limit");

    bin_rdy = 1'b0;
    send_str("AABBCC\n", 0);
    @(posedge clk);
    #1;
    chk("stall bin_vld",  bin_vld,  1);
    chk("stall bin_data", bin_data, 8'hAA);
    chk("stall bin_last", bin_last, 0);
    chk("stall err_code", err_code, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("stall hold bin_data", bin_data, 8'hAA);
    chk("stall hold bin_last", bin_last, 0);
    chk("stall hold bin_err",  bin_err,  0);
    bin_rdy = 1'b1;
    exp_beat(8'hAA, 0, 0);
    exp_beat(8'hBB, 1, 1);
    exp_codes.push_back(2'd3);
    drain_and_compare("overflow");

    bin_rdy = 1'b0;
    send_str("12345", 0);
    chk("pre-reset bin_vld", bin_vld, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset bin_vld",  bin_vld,  0);
    chk("async reset bin_data", bin_data, 0);
    chk("async reset bin_last", bin_last, 0);
    chk("async reset bin_err",  bin_err,  0);
    chk("async reset err_vld",  err_vld,  0);
    chk("async reset err_code", err_code, 0);
`ifdef CHAR2BIN_STATS_EN
    chk("async reset frm_cnt", frm_cnt, 0);
    chk("async reset err_cnt", err_cnt, 0);
`endif
    @(posedge clk);
    #1;
    reset   = 1'b0;
    bin_rdy = 1'b1;
    clear_q();
    send_str("\n56\n", 1);
    exp_beat(8'h56, 1, 0);
    drain_and_compare("after reset");

    for (int round = 0; round < 6; round++) begin
      t.delete();
      for (int line = 0; line < 8; line++) begin
        int n;
        n = int'($urandom_range(0, 12));
        for (int j = 0; j < n; j++) t.push_back(rand_char());
        if ($urandom_range(0, 3) == 0) t.push_back(8'h0D);
        t.push_back(8'h0A);
      end
      model_text(t);
      send_q(t);
      drain_and_compare($sformatf("random round%0d", round));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/char2bin.md
Name: char2bin

Overview:
- Inverse of the bin2char path: converts an ASCII hex character stream (from uart rx_vld/rx_data) into a framed byte stream with last/err markers, for the Ethernet TX path.
- One frame per text line; a line terminator closes the frame.
- One-byte hold stage, so bin_last is asserted on the final byte of the frame and not on a separate beat.
- Valid/ready handshake on the output; no backpressure on the input, because the UART cannot stall.

Parameters:
- MAX_LEN, 1514, maximum bytes per frame; the frame errors when byte MAX_LEN+1 completes.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- char_vld  in  1  one-cycle strobe; char_data is valid
- char_data  in  8  ASCII character
- bin_vld  out  1  output byte valid
- bin_rdy  in  1  downstream accepts when bin_vld&bin_rdy
- bin_data  out  8  output byte
- bin_last  out  1  final byte of the frame
- bin_err  out  1  frame is bad; valid only with bin_last
- err_vld  out  1  one-cycle error pulse
- err_code  out  2  1=illegal char, 2=odd nibble count, 3=overflow/too long; holds its value until the next err_vld

Behaviour:
- Reset (async, active-high): bin_vld, bin_data, bin_last, bin_err, err_vld and err_code = 0. Hold is empty. State = IDLE.
- Character classes:
  - HEX: '0'-'9', 'A'-'F', 'a'-'f' map to a nibble.
  - SEP: 0x20, 0x09, ':'.
  - TERM: 0x0A, 0x0D.
  - Anything else is ILLEGAL.
- States:
  - IDLE: no frame active.
  - HI: frame active, expecting a high nibble.
  - LO: high nibble captured.
  - DISCARD: ignore all characters until TERM.
- Transitions, acting only on char_vld:
  - IDLE: HEX captures the high nibble and goes to LO. SEP and TERM are ignored; an empty line produces no output. ILLEGAL goes to DISCARD with err 1.
  - HI: HEX goes to LO. SEP is ignored. TERM marks the hold final and goes to IDLE. ILLEGAL goes to DISCARD with err 1.
  - LO: HEX completes a byte {hi,lo} and goes to HI. TERM goes to IDLE with err 2. SEP goes to DISCARD with err 2. ILLEGAL goes to DISCARD with err 1.
  - DISCARD: TERM goes to IDLE; every other character is ignored.
- Hold register fields: hold_vld, hold_data, hold_final, hold_err, plus a frame byte counter.
- On byte completion:
  - If hold_vld and the output is free (~bin_vld | bin_rdy): the hold moves to the output with last=0 and the hold takes the new byte.
  - If the hold is empty: the hold takes the new byte.
  - If hold_vld and the output is busy: overflow. The new byte is dropped, err 3 is raised, the hold is marked final and err, and the state goes to DISCARD.
- Any error while hold_vld marks the hold final with hold_err=1.
- Any error with no hold produces no output beats, because no byte of the frame has been emitted.
- Length limit: completing byte MAX_LEN+1 drops that byte, raises err 3, marks the hold final and err, and goes to DISCARD.
- A final hold moves to the output (bin_last=1, bin_err=hold_err) at the first edge where the output is free. The hold is then empty.
- A CR followed by LF: the second terminator sees IDLE and is ignored.
- Timing:
  - The output register loads at the same edge that samples the completing char_vld or TERM, so bin_vld rises the next cycle when the output is free.
  - err_vld is registered on the sampling edge of the offending character.
- bin_data, bin_last and bin_err are stable while bin_vld & ~bin_rdy.
- Frame counter: counts completed bytes and clears when the state enters IDLE.

Optional Feature:
- Macro: CHAR2BIN_STATS_EN.
- Defined: adds outputs frm_cnt[7:0] and err_cnt[7:0].
  - frm_cnt counts beats with bin_last.
  - err_cnt counts err_vld pulses.
  - Both saturate at 0xFF and reset to 0.
  - Intended for the toplevel leds/sw mux.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- "0A1b\n", bin_rdy=1 -> beats 0x0A (last=0), then 0x1B (last=1, err=0); no err_vld.
- "DE:AD BE\r\n" -> 0xDE, 0xAD, 0xBE with last on 0xBE; no extra beat from LF.
- "12G4\n55\n" -> 0x12 last=1 err=1 emitted on 'G', err_code=1; "4" ignored; then 0x55 last=1 err=0.
- "123\n" -> 0x12 last=1 err=1, err_vld with err_code=2 on '\n'; a following "\n" produces nothing.
- MAX_LEN=4, "0102030405\n" -> 01, 02, 03 (last=0), then 04 (last=1, err=1); err_code=3 on completion of 05.
- bin_rdy=0, "AABBCC\n", then bin_rdy=1 -> overflow err 3 on CC; output is AA (last=0), then BB (last=1, err=1); assert reset mid-frame -> all outputs 0 and IDLE immediately.
